serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 146 ++++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. An accepted start latches the operands and the
// initial carry, then one result bit is produced per clock, LSB first. After
// WIDTH bits the full result and the final carry are published on sum/cout
// and done pulses for one cycle.
//
// Handshake: start is a request that is taken on any rising edge where the
// block is IDLE or DONE (rst_n high). There is no backpressure; a start seen
// while busy is dropped silently. done is a one-cycle pulse, and sum/cout stay
// valid from that pulse until the next completion.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   begin an operation (sampled only when accepting)
//   sub    in   0 = add, 1 = subtract (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   cin    in   carry-in for add mode (ignored when sub = 1)
//   busy   out  high while bits are being processed
//   done   out  one-cycle completion pulse
//   sum    out  result of the last completed operation
//   cout   out  final carry of the last completed operation
//                (in subtract mode 1 = no borrow)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;   // holds b' (already inverted for subtract)
  logic [WIDTH-1:0] res_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             s_bit;
  logic             c_next;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // One full-adder slice on the current LSBs of the shifting operands.
  assign s_bit  = a_reg[0] ^ b_reg[0] ^ carry;
  assign c_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and outputs
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      // Subtraction is a + ~b + 1, so the carry starts at 1.
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      carry   <= c_next;
      // Result bits enter from the MSB side so bit 0 ends up at the LSB
      // after WIDTH shifts.
      res_reg <= {s_bit, res_reg[WIDTH-1:1]};
      if (last_bit) begin
        sum  <= {s_bit, res_reg[WIDTH-1:1]};
        cout <= c_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed checks of serial_adder (WIDTH = 8): reset state, add, add with
// carry/wrap, subtract with and without borrow, start ignored while running,
// back-to-back operation and reset in the middle of an operation.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;

  // Clock / reset
  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a_in),
    .b     (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Published result the bench expects to be held on sum/cout.
  logic [WIDTH-1:0] last_sum;
  logic             last_cout;

  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation starting at the current falling edge and checks the
  // full timeline: busy for WIDTH cycles with sum/cout held, a done pulse with
  // the result, then idle. If inject > 0, a different start is presented so
  // that it is sampled at edge E(inject), inside RUN.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a,
                        input logic [WIDTH-1:0] op_b, input logic op_cin,
                        input logic op_sub, input logic [WIDTH-1:0] exp_sum,
                        input logic exp_cout, input int inject);
    start = 1'b1;
    a_in  = op_a;
    b_in  = op_b;
    cin   = op_cin;
    sub   = op_sub;
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == inject - 1) begin
        start = 1'b1;
        a_in  = ~op_a;
        b_in  = op_b + 8'h11;
        sub   = ~op_sub;
      end
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " done_low"}, 32'(done), 32'd0);
      check({tag, " sum_held"}, 32'(sum), 32'(last_sum));
      check({tag, " cout_held"}, 32'(cout), 32'(last_cout));
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'(exp_sum));
    check({tag, " cout"}, 32'(cout), 32'(exp_cout));
    last_sum  = exp_sum;
    last_cout = exp_cout;
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " sum_kept"}, 32'(sum), 32'(last_sum));
  endtask

  // Back-to-back operand table: a, b, cin, sub -> expected sum, cout.
  logic [WIDTH-1:0] bb_a   [3] = '{8'h12, 8'hC8, 8'h05};
  logic [WIDTH-1:0] bb_b   [3] = '{8'h34, 8'h64, 8'h07};
  logic             bb_cin [3] = '{1'b0, 1'b0, 1'b0};
  logic             bb_sub [3] = '{1'b0, 1'b0, 1'b1};
  logic [WIDTH-1:0] bb_sum [3] = '{8'h46, 8'h2C, 8'hFE};
  logic             bb_cout[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    // Reset, with a start presented that must be ignored.
    rst_n = 1'b0;
    start = 1'b1;
    sub   = 1'b0;
    a_in  = 8'($urandom_range(0, 255));
    b_in  = 8'($urandom_range(0, 255));
    cin   = 1'b1;
    last_sum  = '0;
    last_cout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);

    // First start is taken at the first edge with rst_n high.
    rst_n = 1'b1;
    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 0);
    run_op("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0);
    run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 0);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 0);

    // Second start three cycles into RUN must not disturb the first result.
    run_op("start_in_run", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 3);

    // Back-to-back with start held high: done every WIDTH+1 cycles.
    start = 1'b1;
    a_in  = bb_a[0];
    b_in  = bb_b[0];
    cin   = bb_cin[0];
    sub   = bb_sub[0];
    for (int n = 0; n < 3; n++) exp_q.push_back(bb_sum[n]);
    for (int n = 0; n < 3; n++) begin
      logic [WIDTH-1:0] exp_s;
      for (int k = 0; k < WIDTH; k++) begin
        @(negedge clk);
        if (k == 0 && n < 2) begin
          a_in = bb_a[n+1];
          b_in = bb_b[n+1];
          cin  = bb_cin[n+1];
          sub  = bb_sub[n+1];
        end
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b done_low", 32'(done), 32'd0);
      end
      @(negedge clk);
      if (n == 2) start = 1'b0;
      exp_s = exp_q.pop_front();
      check("b2b done", 32'(done), 32'd1);
      check("b2b sum", 32'(sum), 32'(exp_s));
      check("b2b cout", 32'(cout), 32'(bb_cout[n]));
    end
    last_sum  = bb_sum[2];
    last_cout = bb_cout[2];
    @(negedge clk);
    check("b2b stop", 32'(busy), 32'd0);
    check("b2b done_end", 32'(done), 32'd0);

    // Reset while bit 4 would be processed (edge E5); start held during reset.
    start = 1'b1;
    a_in  = 8'h0F;
    b_in  = 8'h01;
    cin   = 1'b0;
    sub   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid done", 32'(done), 32'd0);
    check("rst_mid sum", 32'(sum), 32'd0);
    check("rst_mid cout", 32'(cout), 32'd0);
    last_sum  = '0;
    last_cout = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rst_mid no_done", 32'(done), 32'd0);
      check("rst_mid no_busy", 32'(busy), 32'd0);
    end
    run_op("after_reset", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
